id_ex_skid_reg: RTL and testbench
=================================

Name: id_ex_skid_reg

Overview:
- Parametrised ID->EX pipeline register with valid/ready handshake and a 2-entry skid buffer.
- Carries the decoded control vector, operand data, immediate, PC and register indices from ID to EX.
- Adds stall back-pressure, synchronous flush and bubble (control-zeroing) behaviour.
- Sits between the decode/hazard logic and the EX-stage ALU, forwarding unit and destination mux.

Parameters:
- CTRL_W, 8, width of packed control vector (WB[7:6], M[5:4], ALUSrc[3], ALUOp[2:1], RegDst[0] at default).
- DATA_W, 32, width of rs/rt data, immediate and PC.
- REG_W, 5, register index width.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  ID presents a valid instruction
- in_ready  out  1  block can accept; registered, equals !skid_valid
- ctrl_i  in  CTRL_W  control vector from decode/bubble mux
- pc_i  in  DATA_W  PC+4 of instruction
- rs_data_i  in  DATA_W  register file read port 1
- rt_data_i  in  DATA_W  register file read port 2
- imm_i  in  DATA_W  sign-extended immediate
- rs_i  in  REG_W  instr[25:21]
- rt_i  in  REG_W  instr[20:16]
- rd_i  in  REG_W  instr[15:11]
- flush_i  in  1  discard all held entries (branch/exception)
- out_valid  out  1  EX slot holds a valid instruction
- out_ready  in  1  EX can consume this cycle
- ctrl_o  out  CTRL_W  control vector; forced all-zero when out_valid=0
- pc_o, rs_data_o, rt_data_o, imm_o  out  DATA_W  payload of main slot
- rs_o, rt_o, rd_o  out  REG_W  register indices of main slot

Behaviour:
- Storage:
  - main slot drives the outputs; skid slot holds one overflow entry.
  - State is EMPTY (main_v=0, skid_v=0), ONE (main_v=1, skid_v=0) or FULL (main_v=1, skid_v=1).
- Reset (async, rst_n=0):
  - main_v=0, skid_v=0, so out_valid=0, in_ready=1 and ctrl_o=0.
  - All payload registers go to 0.
  - Reset asserted mid-transfer discards both entries immediately.
- Handshake:
  - Accept when in_valid & in_ready.
  - Consume when out_valid & out_ready.
  - Payload is stable while out_valid & !out_ready.
- Transitions (flush_i=0):
  - EMPTY + accept -> ONE: main loads input; 1-cycle latency to out_valid.
  - ONE + accept + consume -> ONE: main reloads input.
  - ONE + accept + !consume -> FULL: skid loads input; in_ready drops next cycle.
  - ONE + !accept + consume -> EMPTY.
  - FULL + consume -> ONE: main loads skid; in_ready rises next cycle.
  - FULL never accepts, because in_ready=0.
- Ordering: strict FIFO; the skid entry always leaves after the main entry.
- Flush: synchronous, highest priority. Next state is EMPTY regardless of accept/consume in the same cycle; the input offered that cycle is dropped. Payload registers keep their values, but ctrl_o reads 0.
- Bubble: whenever out_valid=0, ctrl_o=0 (no RegWrite/MemWrite reaches EX/MEM). Data outputs are don't-care but stable.
- Simultaneous flush and reset: reset dominates.
- No combinational path from in_valid to in_ready or from out_ready to in_ready.

Optional Feature:
- Macro: ID_EX_PERF_EN.
- When defined:
  - Extra output perf_stall_cnt[15:0].
  - Increments each cycle with out_valid & !out_ready; saturates at 16'hFFFF.
  - Cleared by rst_n and by flush_i.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset: hold rst_n=0 mid-run with FULL state -> out_valid=0, in_ready=1, ctrl_o=8'h00 asynchronously.
- Streaming: in_valid=1 with ctrl_i=8'hC3, rs_data_i=32'h0000_0011 and rs_i=5'd8; out_ready=1 -> next cycle out_valid=1, ctrl_o=8'hC3, rs_data_o=32'h11, rs_o=8; one instruction exits per cycle.
- Stall: push A (pc=32'h4) then B (pc=32'h8) with out_ready=0 -> in_ready=0 after B; raise out_ready -> pc_o=32'h4 then 32'h8; no loss or duplication.
- Flush: FULL state with A,B; assert flush_i=1 with in_valid=1 carrying C -> next cycle out_valid=0, ctrl_o=0, in_ready=1; C never appears.
- Bubble: in_valid=0 with ctrl_i=8'hFF -> ctrl_o stays 8'h00 and out_valid stays 0.
- Perf (ID_EX_PERF_EN): hold out_valid=1 and out_ready=0 for 5 cycles -> perf_stall_cnt=5; flush_i -> 0.

Source files
------------

// File: rtl/id_ex_skid_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_skid_reg_if
// Description : ID->EX handshake and payload bundle. The slave modport is the
//               view of the pipeline register itself; the master modport is
//               the surrounding decode/EX environment. The optional stall
//               counter port exists only when ID_EX_PERF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface id_ex_skid_reg_if #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    // ID side
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] ctrl_i;
    logic [DATA_W-1:0] pc_i;
    logic [DATA_W-1:0] rs_data_i;
    logic [DATA_W-1:0] rt_data_i;
    logic [DATA_W-1:0] imm_i;
    logic [REG_W-1:0]  rs_i;
    logic [REG_W-1:0]  rt_i;
    logic [REG_W-1:0]  rd_i;
    logic              flush_i;

    // EX side
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] ctrl_o;
    logic [DATA_W-1:0] pc_o;
    logic [DATA_W-1:0] rs_data_o;
    logic [DATA_W-1:0] rt_data_o;
    logic [DATA_W-1:0] imm_o;
    logic [REG_W-1:0]  rs_o;
    logic [REG_W-1:0]  rt_o;
    logic [REG_W-1:0]  rd_o;

`ifdef ID_EX_PERF_EN
    logic [15:0]       perf_stall_cnt;
`endif

    modport slave (
        input  in_valid, ctrl_i, pc_i, rs_data_i, rt_data_i, imm_i,
               rs_i, rt_i, rd_i, flush_i, out_ready,
`ifdef ID_EX_PERF_EN
        output perf_stall_cnt,
`endif
        output in_ready, out_valid, ctrl_o, pc_o, rs_data_o, rt_data_o,
               imm_o, rs_o, rt_o, rd_o
    );

    modport master (
        output in_valid, ctrl_i, pc_i, rs_data_i, rt_data_i, imm_i,
               rs_i, rt_i, rd_i, flush_i, out_ready,
`ifdef ID_EX_PERF_EN
        input  perf_stall_cnt,
`endif
        input  in_ready, out_valid, ctrl_o, pc_o, rs_data_o, rt_data_o,
               imm_o, rs_o, rt_o, rd_o
    );
endinterface
`default_nettype wire

// File: rtl/id_ex_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_skid_reg
// Description : ID->EX pipeline register with valid/ready handshake and a
//               two-entry (main + skid) buffer. Synchronous flush empties both
//               entries; ctrl_o is forced to zero whenever no valid entry is
//               presented, so a bubble can never write registers or memory.
//               Optional macro ID_EX_PERF_EN adds a saturating 16-bit counter
//               of cycles where EX holds a valid entry but is not ready.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_skid_reg #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    id_ex_skid_reg_if.slave    bus
);

    localparam int PAY_W = CTRL_W + 4*DATA_W + 3*REG_W;

    // Occupancy: EMPTY = (0,0), ONE = (1,0), FULL = (1,1)
    logic              r_main_v;
    logic              r_skid_v;
    logic [PAY_W-1:0]  r_main_pay;
    logic [PAY_W-1:0]  r_skid_pay;

    logic [PAY_W-1:0]  w_in_pay;
    logic [CTRL_W-1:0] w_main_ctrl;
    logic              w_accept;
    logic              w_consume;

    assign w_in_pay = {bus.ctrl_i, bus.pc_i, bus.rs_data_i, bus.rt_data_i,
                       bus.imm_i, bus.rs_i, bus.rt_i, bus.rd_i};

    // in_ready comes straight from a flop, so neither in_valid nor out_ready
    // reaches it combinationally.
    assign bus.in_ready  = ~r_skid_v;
    assign bus.out_valid = r_main_v;

    assign w_accept  = bus.in_valid & ~r_skid_v;
    assign w_consume = r_main_v & bus.out_ready;

    assign {w_main_ctrl, bus.pc_o, bus.rs_data_o, bus.rt_data_o,
            bus.imm_o, bus.rs_o, bus.rt_o, bus.rd_o} = r_main_pay;

    // Bubble: an empty slot presents an all-zero control vector.
    assign bus.ctrl_o = r_main_v ? w_main_ctrl : '0;

    // Occupancy and payload update; flush wins over any handshake, and the
    // skid entry always moves into main before anything newer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_v   <= 1'b0;
            r_skid_v   <= 1'b0;
            r_main_pay <= '0;
            r_skid_pay <= '0;
        end else if (bus.flush_i) begin
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
        end else if (!r_main_v) begin
            if (w_accept) begin
                r_main_pay <= w_in_pay;
                r_main_v   <= 1'b1;
            end
        end else if (!r_skid_v) begin
            if (w_accept && w_consume) begin
                r_main_pay <= w_in_pay;
            end else if (w_accept) begin
                r_skid_pay <= w_in_pay;
                r_skid_v   <= 1'b1;
            end else if (w_consume) begin
                r_main_v <= 1'b0;
            end
        end else begin
            if (w_consume) begin
                r_main_pay <= r_skid_pay;
                r_skid_v   <= 1'b0;
            end
        end
    end

`ifdef ID_EX_PERF_EN
    logic [15:0] r_stall_cnt;

    assign bus.perf_stall_cnt = r_stall_cnt;

    // Count back-pressured cycles, saturating; flush restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= 16'h0000;
        end else if (bus.flush_i) begin
            r_stall_cnt <= 16'h0000;
        end else if (r_main_v && !bus.out_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'h0001;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_ex_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_skid_reg
// Description : Directed self-checking bench for id_ex_skid_reg: reset,
//               bubble, streaming, stall/skid ordering, flush, asynchronous
//               reset from FULL and (with ID_EX_PERF_EN) the stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_skid_reg;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    id_ex_skid_reg_if #(.CTRL_W(8), .DATA_W(32), .REG_W(5)) bus ();

    id_ex_skid_reg #(.CTRL_W(8), .DATA_W(32), .REG_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] c, input logic [31:0] pc,
                         input logic [31:0] rsd, input logic [4:0] rs);
        bus.in_valid  = v;
        bus.ctrl_i    = c;
        bus.pc_i      = pc;
        bus.rs_data_i = rsd;
        bus.rs_i      = rs;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.in_valid  = 1'b0;
        bus.ctrl_i    = '0;
        bus.pc_i      = '0;
        bus.rs_data_i = '0;
        bus.rt_data_i = 32'h0000_0077;
        bus.imm_i     = 32'hFFFF_FFF0;
        bus.rs_i      = '0;
        bus.rt_i      = 5'd3;
        bus.rd_i      = 5'd9;
        bus.flush_i   = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("rst_ctrl_o",    64'(bus.ctrl_o),    64'h00);
        chk("rst_pc_o",      64'(bus.pc_o),      64'h0);
        rst_n = 1'b1;

        // Bubble: ctrl_i ignored without in_valid
        bus.out_ready = 1'b1;
        drive(1'b0, 8'hFF, 32'h0, 32'h0, 5'd0);
        step();
        chk("bubble_out_valid", 64'(bus.out_valid), 64'd0);
        chk("bubble_ctrl_o",    64'(bus.ctrl_o),    64'h00);
        step();
        chk("bubble_ctrl_o_2",  64'(bus.ctrl_o),    64'h00);

        // Streaming: one instruction per cycle
        drive(1'b1, 8'hC3, 32'h100, 32'h0000_0011, 5'd8);
        step();
        chk("stream_out_valid", 64'(bus.out_valid), 64'd1);
        chk("stream_ctrl_o",    64'(bus.ctrl_o),    64'hC3);
        chk("stream_rs_data_o", 64'(bus.rs_data_o), 64'h11);
        chk("stream_rs_o",      64'(bus.rs_o),      64'd8);
        chk("stream_rt_data_o", 64'(bus.rt_data_o), 64'h77);
        chk("stream_imm_o",     64'(bus.imm_o),     64'hFFFF_FFF0);
        chk("stream_rd_o",      64'(bus.rd_o),      64'd9);
        drive(1'b1, 8'hA5, 32'h104, 32'h0000_0022, 5'd4);
        step();
        chk("stream2_ctrl_o",   64'(bus.ctrl_o),    64'hA5);
        chk("stream2_pc_o",     64'(bus.pc_o),      64'h104);
        chk("stream2_in_ready", 64'(bus.in_ready),  64'd1);
        drive(1'b0, 8'h00, 32'h0, 32'h0, 5'd0);
        step();
        chk("stream_drain_valid", 64'(bus.out_valid), 64'd0);
        chk("stream_drain_ctrl",  64'(bus.ctrl_o),    64'h00);

        // Stall: A then B with EX blocked, then drain in order
        bus.out_ready = 1'b0;
        drive(1'b1, 8'h81, 32'h4, 32'h0, 5'd1);
        step();
        chk("stall_a_valid",    64'(bus.out_valid), 64'd1);
        chk("stall_a_in_ready", 64'(bus.in_ready),  64'd1);
        chk("stall_a_pc_o",     64'(bus.pc_o),      64'h4);
        drive(1'b1, 8'h42, 32'h8, 32'h0, 5'd2);
        step();
        chk("stall_full_in_ready", 64'(bus.in_ready), 64'd0);
        chk("stall_full_pc_o",     64'(bus.pc_o),     64'h4);
        drive(1'b1, 8'h33, 32'hC, 32'h0, 5'd3);
        step();
        chk("stall_hold_pc_o",     64'(bus.pc_o),     64'h4);
        chk("stall_hold_ctrl_o",   64'(bus.ctrl_o),   64'h81);
        chk("stall_hold_in_ready", 64'(bus.in_ready), 64'd0);
        drive(1'b0, 8'h00, 32'h0, 32'h0, 5'd0);
        bus.out_ready = 1'b1;
        step();
        chk("drain_b_pc_o",     64'(bus.pc_o),      64'h8);
        chk("drain_b_ctrl_o",   64'(bus.ctrl_o),    64'h42);
        chk("drain_b_in_ready", 64'(bus.in_ready),  64'd1);
        step();
        chk("drain_empty_valid", 64'(bus.out_valid), 64'd0);

        // Flush from FULL with C offered the same cycle
        bus.out_ready = 1'b0;
        drive(1'b1, 8'h11, 32'h10, 32'h0, 5'd5);
        step();
        drive(1'b1, 8'h22, 32'h14, 32'h0, 5'd6);
        step();
        chk("flush_pre_in_ready", 64'(bus.in_ready), 64'd0);
        drive(1'b1, 8'hFF, 32'h18, 32'h0, 5'd7);
        bus.flush_i = 1'b1;
        step();
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_ctrl_o",    64'(bus.ctrl_o),    64'h00);
        chk("flush_in_ready",  64'(bus.in_ready),  64'd1);
        chk("flush_pc_kept",   64'(bus.pc_o),      64'h10);
        bus.flush_i = 1'b0;
        drive(1'b0, 8'h00, 32'h0, 32'h0, 5'd0);
        bus.out_ready = 1'b1;
        step();
        chk("flush_no_c_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_no_c_pc",    64'(bus.pc_o),      64'h10);

        // Asynchronous reset from FULL
        bus.out_ready = 1'b0;
        drive(1'b1, 8'h55, 32'h20, 32'h0, 5'd1);
        step();
        drive(1'b1, 8'h66, 32'h24, 32'h0, 5'd2);
        step();
        chk("full_before_rst", 64'(bus.in_ready), 64'd0);
        drive(1'b0, 8'h00, 32'h0, 32'h0, 5'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("arst_ctrl_o",    64'(bus.ctrl_o),    64'h00);
        chk("arst_pc_o",      64'(bus.pc_o),      64'h0);
        step();
        rst_n = 1'b1;

`ifdef ID_EX_PERF_EN
        // Stall counter: five blocked cycles, then flush clears
        chk("perf_after_rst", 64'(bus.perf_stall_cnt), 64'd0);
        drive(1'b1, 8'h77, 32'h30, 32'h0, 5'd1);
        step();
        drive(1'b0, 8'h00, 32'h0, 32'h0, 5'd0);
        for (int i = 0; i < 5; i++) step();
        chk("perf_five", 64'(bus.perf_stall_cnt), 64'd5);
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        chk("perf_flush", 64'(bus.perf_stall_cnt), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
